// File: rtl/codificador_teclado.sv
// Keypad front-end for the microwave input encoder: synchronizes ten raw
// digit lines, debounces press and release, rejects multi-key presses, and
// emits a BCD code with a one-cycle valid strobe per accepted press.
module codificador_teclado #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] keypad,
    output logic [3:0] bcd,
    output logic       valid,
    output logic       key_held
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        ACCEPT,
        HELD,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [9:0]       sync1;
    logic [9:0]       ks;
    logic [9:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand_idx;
    logic             ks_single;

    // Two-flop synchronizer for the asynchronous key lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            ks    <= '0;
        end else begin
            sync1 <= keypad;
            ks    <= sync1;
        end
    end

    // Classify the synchronized pattern: exactly one key down.
    always_comb begin
        ks_single = (ks != '0) && ((ks & (ks - 10'd1)) == '0);
    end

    // Binary index of the candidate key (candidate is always one-hot).
    always_comb begin
        cand_idx = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (cand[i]) cand_idx = 4'(i);
        end
    end

    // Press/release state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cand     <= '0;
            cnt      <= '0;
            bcd      <= '0;
            valid    <= 1'b0;
            key_held <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable && ks_single) begin
                        cand  <= ks;
                        cnt   <= CNT_ONE;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if ((ks != cand) || !enable) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        // Outputs are loaded on entry so the strobe and code
                        // are visible during the ACCEPT cycle itself.
                        bcd      <= cand_idx;
                        valid    <= 1'b1;
                        key_held <= 1'b1;
                        cnt      <= '0;
                        state    <= ACCEPT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACCEPT: begin
                    state <= HELD;
                end
                HELD: begin
                    if (ks == '0) begin
                        cnt   <= CNT_ONE;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (ks != '0) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        key_held <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
